spi_flash_reader: RTL and testbench

//  Memory-mapped bus responder that serves CPU word reads from the external SPI flash.
//  It sits behind the address decoder alongside ram, uart and timer, and drives the

---
 rtl/spi_flash_reader_if.sv | 19 +
 rtl/spi_flash_reader.sv | 178 +++++++++++++++++
 tb/tb_spi_flash_reader.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_reader_if.sv
// Bus-side handshake between the CPU address decoder and the SPI flash read responder.
interface spi_flash_reader_if;
    logic [63:0] address_in;
    logic        sel_in;
    logic        read_in;
    logic [3:0]  write_mask_in;
    logic [63:0] read_value_out;
    logic        ready_out;

    modport master (
        output address_in, sel_in, read_in, write_mask_in,
        input  read_value_out, ready_out
    );

    modport slave (
        input  address_in, sel_in, read_in, write_mask_in,
        output read_value_out, ready_out
    );
endinterface

// File: rtl/spi_flash_reader.sv
// Serves 32-bit bus reads from an external SPI flash using mode-0 READ (0x03) transactions.
// Wakes the flash with 0xAB after reset; writes complete immediately with no SPI activity.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_WAKE  | first cycle raises csn low, then shifts 0xAB out
// S_WWAIT | csn high for WAKE_WAIT cycles while the flash powers up
// S_IDLE  | waiting for a selected bus read or write
// S_SHIFT | 32 TX bits (cmd + address) then 32 RX bits
// S_DONE  | one-cycle ready_out pulse with the assembled read data
module spi_flash_reader #(
    parameter int          CLK_DIV      = 2,
    parameter logic [23:0] FLASH_OFFSET = 24'h100000,
    parameter int          WAKE_WAIT    = 64
) (
    input  logic               clk,
    input  logic               reset,
    spi_flash_reader_if.slave  bus,
    output logic               flash_clk,
    output logic               flash_csn,
    output logic               flash_io0_out,
    output logic               flash_io0_en,
    input  logic               flash_io1_in,
    output logic               flash_io1_en
);

    typedef enum logic [2:0] {
        S_WAKE,
        S_WWAIT,
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [15:0] DIV_LOAD  = 16'(CLK_DIV - 1);
    localparam logic [15:0] WAIT_LOAD = 16'(WAKE_WAIT - 1);
    localparam logic [7:0]  WAKE_CMD  = 8'hAB;
    localparam logic [7:0]  READ_CMD  = 8'h03;

    state_t      state_q, state_d;
    logic        csn_q, csn_d;
    logic        sck_q, sck_d;
    logic        io0_q, io0_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d;

    logic [23:0] flash_addr;
    logic [31:0] read_word;
    logic        accept_read;
    logic        accept_write;
    logic        last_bit;
    logic        unused_addr_bits;

    assign flash_addr   = {bus.address_in[23:2], 2'b00} + FLASH_OFFSET;
    assign read_word    = {READ_CMD, flash_addr};
    assign accept_read  = bus.sel_in & bus.read_in;
    assign accept_write = bus.sel_in & (|bus.write_mask_in) & ~bus.read_in;
    assign last_bit     = (state_q == S_WAKE) ? (bit_cnt_q == 6'd7) : (bit_cnt_q == 6'd63);
    assign unused_addr_bits = ^{bus.address_in[63:24], bus.address_in[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_WAKE;
            csn_q     <= 1'b1;
            sck_q     <= 1'b0;
            io0_q     <= 1'b0;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
        end else begin
            state_q   <= state_d;
            csn_q     <= csn_d;
            sck_q     <= sck_d;
            io0_q     <= io0_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        csn_d     = csn_q;
        sck_d     = sck_q;
        io0_d     = io0_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;

        case (state_q)
            S_WAKE, S_SHIFT: begin
                if (state_q == S_WAKE && csn_q) begin
                    // Leaving reset: open the wake frame with the first command bit on io0.
                    csn_d     = 1'b0;
                    sck_d     = 1'b0;
                    io0_d     = WAKE_CMD[7];
                    tx_d      = {WAKE_CMD[6:0], 25'b0};
                    cnt_d     = DIV_LOAD;
                    bit_cnt_d = '0;
                end else if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (!sck_q) begin
                    sck_d = 1'b1;
                    cnt_d = DIV_LOAD;
                end else begin
                    // End of the high phase: sample MISO, then move io0 while SCK is low.
                    sck_d = 1'b0;
                    cnt_d = DIV_LOAD;
                    if (state_q == S_SHIFT && bit_cnt_q[5]) begin
                        rx_d = {rx_q[30:0], flash_io1_in};
                    end
                    if (last_bit) begin
                        csn_d = 1'b1;
                        io0_d = 1'b0;
                        if (state_q == S_WAKE) begin
                            state_d = S_WWAIT;
                            cnt_d   = WAIT_LOAD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        io0_d     = tx_q[31];
                        tx_d      = {tx_q[30:0], 1'b0};
                    end
                end
            end
            S_WWAIT: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_IDLE: begin
                if (accept_read) begin
                    state_d   = S_SHIFT;
                    csn_d     = 1'b0;
                    sck_d     = 1'b0;
                    io0_d     = read_word[31];
                    tx_d      = {read_word[30:0], 1'b0};
                    cnt_d     = DIV_LOAD;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                end else if (accept_write) begin
                    state_d = S_DONE;
                    rx_d    = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_WAKE;
                csn_d   = 1'b1;
                sck_d   = 1'b0;
            end
        endcase
    end

    assign bus.ready_out      = (state_q == S_DONE);
    // First byte received is the lowest-addressed one; place it in the low lane.
    assign bus.read_value_out = bus.ready_out
                              ? {32'b0, rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]}
                              : 64'b0;

    assign flash_clk     = sck_q;
    assign flash_csn     = csn_q;
    assign flash_io0_out = io0_q;
    assign flash_io0_en  = 1'b1;
    assign flash_io1_en  = 1'b0;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader: SPI flash model, scoreboard queue and bus monitor.
module tb_spi_flash_reader;

    localparam int          WAKE_WAIT = 64;
    localparam logic [23:0] OFFSET    = 24'h100000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_flash_reader_if bus_if();

    logic flash_clk, flash_csn, flash_io0_out, flash_io0_en, flash_io1_en;
    logic flash_io1_in = 1'b0;

    spi_flash_reader #(
        .CLK_DIV     (2),
        .FLASH_OFFSET(OFFSET),
        .WAKE_WAIT   (WAKE_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_if),
        .flash_clk    (flash_clk),
        .flash_csn    (flash_csn),
        .flash_io0_out(flash_io0_out),
        .flash_io0_en (flash_io0_en),
        .flash_io1_in (flash_io1_in),
        .flash_io1_en (flash_io1_en)
    );

    typedef struct {
        bit          is_read;
        logic [63:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] cmd_q[$];
    logic [7:0]  mem [logic [23:0]];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fall_cnt = 0;
    int fall_cyc = 0;
    int sck_rises = 0;
    int wake_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Flash contents: explicit bytes where loaded, otherwise a fixed address hash.
    function automatic logic [7:0] fbyte(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endfunction

    function automatic logic [23:0] ref_addr(input logic [63:0] addr);
        return {addr[23:2], 2'b00} + OFFSET;
    endfunction

    function automatic logic [63:0] ref_read(input logic [63:0] addr);
        logic [23:0] a;
        a = ref_addr(addr);
        return {32'b0, fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
    endfunction

    // Mode-0 SPI flash: MOSI captured on SCK rise, MISO updated after SCK fall.
    initial begin : flash_model
        logic        pcsn, psck, tail_bad;
        logic [31:0] mosi_sh;
        logic [23:0] faddr;
        logic [7:0]  cur;
        int          rise_cnt, k;
        pcsn = 1'b1; psck = 1'b0; tail_bad = 1'b0;
        mosi_sh = '0; faddr = '0; rise_cnt = 0; k = 0; cur = '0;
        forever begin
            @(flash_csn or flash_clk);
            if (flash_csn !== pcsn) begin
                if (flash_csn === 1'b0) begin
                    rise_cnt = 0; mosi_sh = '0; tail_bad = 1'b0;
                end else if (rise_cnt == 8) begin
                    check("wake_cmd", {56'b0, mosi_sh[7:0]}, 64'hAB);
                    wake_seen++;
                end else if (rise_cnt == 64) begin
                    check("mosi_tail_zero", {63'b0, tail_bad}, 64'b0);
                    if (cmd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL mosi_cmd: got %h required no transaction", mosi_sh);
                    end else begin
                        check("mosi_cmd", {32'b0, mosi_sh}, {32'b0, cmd_q.pop_front()});
                    end
                end
            end
            if (flash_clk !== psck && flash_csn === 1'b0) begin
                if (flash_clk === 1'b1) begin
                    if (rise_cnt < 32) mosi_sh = {mosi_sh[30:0], flash_io0_out};
                    else if (flash_io0_out !== 1'b0) tail_bad = 1'b1;
                    rise_cnt++;
                    if (rise_cnt == 32) faddr = mosi_sh[23:0];
                end else if (rise_cnt >= 32 && rise_cnt < 64) begin
                    k = rise_cnt - 32;
                    cur = fbyte(faddr + 24'(k / 8));
                    flash_io1_in = cur[7 - (k % 8)];
                end
            end
            pcsn = flash_csn;
            psck = flash_clk;
        end
    end

    // Monitor: pops the scoreboard whenever ready_out pulses.
    initial begin : monitor
        logic prev_csn, prev_sck;
        int   high_cnt;
        exp_t e;
        prev_csn = 1'b1; prev_sck = 1'b0; high_cnt = 0;
        forever begin
            @(negedge clk);
            if (flash_clk === 1'b1 && prev_sck === 1'b0) sck_rises++;
            if (flash_csn === 1'b1) high_cnt++;
            if (flash_csn === 1'b0 && prev_csn === 1'b1) begin
                check("csn_gap", {63'b0, high_cnt >= 1}, 64'd1);
                fall_cnt++;
                fall_cyc = cyc;
                high_cnt = 0;
            end
            if (bus_if.ready_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ready: got ready value %h required none", bus_if.read_value_out);
                end else begin
                    e = exp_q.pop_front();
                    check("read_value", bus_if.read_value_out, e.val);
                    if (e.is_read) check("latency", 64'(cyc - fall_cyc), 64'd256);
                end
            end else begin
                check("idle_value_zero", bus_if.read_value_out, 64'b0);
            end
            prev_csn = flash_csn;
            prev_sck = flash_clk;
        end
    end

    task automatic do_read(input logic [63:0] addr, input bit drop_sel, input bit keep);
        exp_t e;
        bit   got;
        e.is_read = 1'b1;
        e.val     = ref_read(addr);
        exp_q.push_back(e);
        cmd_q.push_back({8'h03, ref_addr(addr)});
        bus_if.address_in    = addr;
        bus_if.sel_in        = 1'b1;
        bus_if.read_in       = 1'b1;
        bus_if.write_mask_in = 4'($urandom);
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (drop_sel && flash_csn === 1'b0) bus_if.sel_in = 1'b0;
            if (bus_if.ready_out === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL read_timeout: addr %h got no ready required ready", addr);
            exp_q.delete();
            cmd_q.delete();
        end
        if (!keep) begin
            bus_if.sel_in = 1'b0; bus_if.read_in = 1'b0; bus_if.write_mask_in = 4'b0;
        end
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [3:0] m);
        exp_t e;
        int   f0;
        @(negedge clk);
        f0 = fall_cnt;
        e.is_read = 1'b0;
        e.val     = 64'b0;
        exp_q.push_back(e);
        bus_if.address_in    = addr;
        bus_if.sel_in        = 1'b1;
        bus_if.read_in       = 1'b0;
        bus_if.write_mask_in = m;
        @(posedge clk);
        #1;
        check("write_ready", {63'b0, bus_if.ready_out}, 64'd1);
        @(negedge clk);
        bus_if.sel_in = 1'b0; bus_if.write_mask_in = 4'b0;
        repeat (2) @(negedge clk);
        check("write_no_csn", 64'(fall_cnt - f0), 64'd0);
    endtask

    task automatic no_sel(input int n);
        int f0;
        f0 = fall_cnt;
        bus_if.sel_in = 1'b0;
        repeat (n) begin
            bus_if.read_in       = 1'($urandom);
            bus_if.write_mask_in = 4'($urandom);
            bus_if.address_in    = {$urandom, $urandom};
            @(negedge clk);
        end
        bus_if.read_in = 1'b0; bus_if.write_mask_in = 4'b0;
        check("nosel_no_csn", 64'(fall_cnt - f0), 64'd0);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit ok;
        int r0, w0, hi;
        bus_if.address_in = '0; bus_if.sel_in = 1'b0;
        bus_if.read_in = 1'b0; bus_if.write_mask_in = 4'b0;
        mem[24'h100004] = 8'h11; mem[24'h100005] = 8'h22;
        mem[24'h100006] = 8'h33; mem[24'h100007] = 8'h44;
        mem[24'h100008] = 8'h55; mem[24'h100009] = 8'h66;
        mem[24'h10000A] = 8'h77; mem[24'h10000B] = 8'h88;

        repeat (3) @(posedge clk);
        #1;
        check("rst_csn", {63'b0, flash_csn}, 64'd1);
        check("rst_sck", {63'b0, flash_clk}, 64'd0);
        check("rst_io0", {63'b0, flash_io0_out}, 64'd0);
        check("rst_ready", {63'b0, bus_if.ready_out}, 64'd0);
        check("rst_value", bus_if.read_value_out, 64'b0);
        check("io_enables", {62'b0, flash_io0_en, flash_io1_en}, 64'b10);

        // Wake sequence
        @(negedge clk);
        reset = 1'b0;
        w0 = wake_seen;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (flash_csn === 1'b0) ok = 1'b1;
        end
        check("wake_csn_low", {63'b0, ok}, 64'd1);
        r0 = sck_rises;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (flash_csn === 1'b1) ok = 1'b1;
        end
        check("wake_csn_high", {63'b0, ok}, 64'd1);
        check("wake_sck_pulses", 64'(sck_rises - r0), 64'd8);
        check("wake_cmd_seen", 64'(wake_seen - w0), 64'd1);
        hi = 1;
        for (int i = 1; i < WAKE_WAIT; i++) begin
            @(negedge clk);
            if (flash_csn === 1'b1) hi++;
        end
        check("wake_wait_high", 64'(hi), 64'(WAKE_WAIT));

        // First IDLE cycle: write completes next cycle without touching csn
        do_write(64'h0, 4'b0001);

        do_read(64'h4, 1'b0, 1'b0);
        do_read(64'h6, 1'b0, 1'b0);
        do_write(64'h0, 4'b0001);
        do_read(64'h8, 1'b1, 1'b0);
        no_sel(12);

        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0, 1: do_read({$urandom, $urandom}, 1'($urandom), 1'b0);
                2:    do_write({$urandom, $urandom}, 4'($urandom_range(1, 15)));
                default: no_sel(5);
            endcase
        end

        // Back-to-back reads with the request held through DONE
        do_read(64'h4, 1'b0, 1'b1);
        do_read(64'h8, 1'b0, 1'b0);

        // Request held one cycle past DONE must not start another transaction
        do_read(64'hC, 1'b0, 1'b1);
        @(negedge clk);
        bus_if.sel_in = 1'b0; bus_if.read_in = 1'b0;
        no_sel(10);

        // Reset during the address bits
        exp_q.push_back('{1'b1, ref_read(64'h4)});
        cmd_q.push_back({8'h03, ref_addr(64'h4)});
        bus_if.address_in = 64'h4; bus_if.sel_in = 1'b1; bus_if.read_in = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (flash_csn === 1'b0) ok = 1'b1;
        end
        check("abort_started", {63'b0, ok}, 64'd1);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        bus_if.sel_in = 1'b0; bus_if.read_in = 1'b0;
        exp_q.delete();
        cmd_q.delete();
        w0 = wake_seen;
        @(posedge clk);
        #1;
        check("abort_csn", {63'b0, flash_csn}, 64'd1);
        check("abort_sck", {63'b0, flash_clk}, 64'd0);
        check("abort_ready", {63'b0, bus_if.ready_out}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        do_read(64'h4, 1'b0, 1'b0);
        check("rewake_seen", 64'(wake_seen - w0), 64'd1);

        repeat (10) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("cmd_queue_empty", 64'(cmd_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
